// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block (uart_tx / uart_rx).
//   - uart_state_e : receiver/transmitter state encoding
//                    (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   - UART_WIDTH, UART_SAMPLING_TICKS : default frame width and oversampling
//   - clog2_min1() : $clog2 that never returns 0, so that counters sized from
//                    a parameter of 1 still get a legal 1-bit width
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_WIDTH          = 8;
    localparam int UART_SAMPLING_TICKS = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small show-ahead receive FIFO (same structure as the uart_tx FIFO).
// Parameters:
//   WIDTH      - entry width
//   FIFO_DEPTH - number of entries, power of 2, >= 2
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write request and data
//   pop             - read request (ignored while empty)
//   pop_data        - current head entry (valid while empty=0)
//   empty, full     - status
// A push while full is accepted only if a pop happens in the same cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH      = UART_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2_min1(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Entries are cleared on reset so the show-ahead head reads 0 after reset.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: oversamples rx at SAMPLING_TICKS per bit, deserialises
// frames LSB first and pushes good bytes into a small show-ahead FIFO.
// Parameters:
//   WIDTH          - data bits per frame
//   SAMPLING_TICKS - oversampling ticks per bit (even, >= 4)
//   TICK_DIV       - clk cycles per sampling tick
//   FIFO_DEPTH     - receive FIFO entries (power of 2)
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   rx         - serial line (idle high, asynchronous to clk)
//   rd_en      - pop FIFO head
//   data_out   - FIFO head, valid while empty=0
//   empty/full - FIFO status
//   busy       - frame in progress
//   frame_err  - 1-cycle pulse: stop bit sampled low
//   overflow   - 1-cycle pulse: good byte dropped, FIFO full
//   parity_err - (UART_RX_PARITY_EN only) 1-cycle pulse: even parity mismatch
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (8E1); undefined gives 8N1.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH          = UART_WIDTH,
    parameter int SAMPLING_TICKS = UART_SAMPLING_TICKS,
    parameter int TICK_DIV       = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
`ifdef UART_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int SW = clog2_min1(SAMPLING_TICKS);
    localparam int NW = clog2_min1(WIDTH);
    localparam int TW = clog2_min1(TICK_DIV);

    localparam logic [SW-1:0] S_MID  = SW'(SAMPLING_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SAMPLING_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(WIDTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rxs_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Sampling tick generator
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_reg;
    logic          tick;

    assign tick = (tick_cnt_reg == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_state_e      state_reg;
    logic [SW-1:0]    s_cnt_reg;
    logic [NW-1:0]    n_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             frame_err_reg;
    logic             overflow_reg;
    logic             parity_bad;
    logic             stop_sample;
    logic             stop_good;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;
    logic parity_err_reg;
    assign parity_bad = parity_bad_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_bad = 1'b0;
`endif

    // Stop-bit sampling instant; a good byte is pushed on this very edge so
    // empty falls the clk after the stop-bit sample.
    assign stop_sample = tick && (state_reg == STOP) && (s_cnt_reg == S_LAST);
    assign stop_good   = stop_sample && rxs_reg && !parity_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            s_cnt_reg      <= '0;
            n_reg          <= '0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            if (tick) begin
                case (state_reg)
                    IDLE: begin
                        if (!rxs_reg) begin
                            state_reg <= START;
                            s_cnt_reg <= '0;
                        end
                    end
                    START: begin
                        // Re-check the line half a bit in: a high level here
                        // means the falling edge was a glitch.
                        if (s_cnt_reg == S_MID) begin
                            s_cnt_reg <= '0;
                            if (!rxs_reg) begin
                                state_reg <= DATA;
                                n_reg     <= '0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    DATA: begin
                        if (s_cnt_reg == S_LAST) begin
                            s_cnt_reg <= '0;
                            shift_reg <= {rxs_reg, shift_reg[WIDTH-1:1]};
                            if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= PARITY;
`else
                                state_reg <= STOP;
`endif
                            end else begin
                                n_reg <= n_reg + NW'(1);
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (s_cnt_reg == S_LAST) begin
                            s_cnt_reg      <= '0;
                            // Even parity: data bits plus parity bit XOR to 0.
                            parity_bad_reg <= rxs_reg ^ (^shift_reg);
                            state_reg      <= STOP;
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (s_cnt_reg == S_LAST) begin
                            s_cnt_reg <= '0;
                            state_reg <= IDLE;
                            if (!rxs_reg) begin
                                frame_err_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (parity_bad_reg) begin
                                parity_err_reg <= 1'b1;
`endif
                            end else if (fifo_full && !rd_en) begin
                                // A same-cycle pop frees a slot, so only drop
                                // when nothing is being read.
                                overflow_reg <= 1'b1;
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        s_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    uart_rx_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stop_good),
        .push_data (shift_reg),
        .pop       (rd_en),
        .pop_data  (data_out),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign empty = fifo_empty;
    assign full  = fifo_full;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at 16 clk per bit. Stimulus tasks push the
// bytes expected to reach the FIFO into exp_q; a monitor drains the FIFO
// while auto_read is set and compares every popped byte with the queue head.
// The monitor also counts error pulses and checks they last one clk.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       busy;
    logic       frame_err;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .WIDTH          (8),
        .SAMPLING_TICKS (16),
        .TICK_DIV       (1),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    bit         auto_read = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    logic       fe_prev = 1'b0;
    logic       ov_prev = 1'b0;
    logic       pe_prev = 1'b0;
    int         lat;
    int         base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: decides rd_en on the falling edge so the pop
    // happens on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            rd_en   = 1'b0;
            fe_prev = 1'b0;
            ov_prev = 1'b0;
            pe_prev = 1'b0;
        end else begin
            rd_en = 1'b0;
            if (auto_read && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no data", data_out);
                end else begin
                    check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
                rd_en = 1'b1;
            end
            if (frame_err) begin
                fe_cnt++;
                check("frame_err_1clk", {31'd0, fe_prev}, 32'd0);
            end
            if (overflow) begin
                ov_cnt++;
                check("overflow_1clk", {31'd0, ov_prev}, 32'd0);
            end
            fe_prev = frame_err;
            ov_prev = overflow;
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                pe_cnt++;
                check("parity_err_1clk", {31'd0, pe_prev}, 32'd0);
            end
            pe_prev = parity_err;
`endif
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // One frame starting at the current falling edge. par_flip inverts the
    // (even) parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) begin
            drive_bit(1'b1);
        end
`endif
        drive_bit(stop_bit);
    endtask

    task automatic wait_not_empty(input int budget, output int waited);
        waited = 0;
        while (empty && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] loop_bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("reset_empty",     {31'd0, empty},     32'd1);
        check("reset_full",      {31'd0, full},      32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overflow",  {31'd0, overflow},  32'd0);
        check("reset_data_out",  {24'd0, data_out},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, no reads: latency and show-ahead data
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                wait_not_empty(200, lat);
                check("a5_empty_fell", {31'd0, empty}, 32'd0);
                check("a5_latency_150_165", {31'd0, (lat >= 150 && lat <= 165)}, 32'd1);
                check("a5_data_out", {24'd0, data_out}, 32'hA5);
            end
        join
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        check("a5_no_frame_err", fe_cnt, 32'd0);
        auto_read = 1'b1;
        repeat (5) @(negedge clk);
        check("a5_drained", {31'd0, empty}, 32'd1);

        // Back-to-back frames read one per frame
        foreach (loop_bytes[i]) begin
            exp_q.push_back(loop_bytes[i]);
            send_frame(loop_bytes[i], 1'b1, 1'b0);
        end
        repeat (5) @(negedge clk);
        check("loop_all_read", exp_q.size(), 32'd0);
        check("loop_no_frame_err", fe_cnt, 32'd0);
        check("loop_no_overflow", ov_cnt, 32'd0);

        // Short low glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_empty", {31'd0, empty}, 32'd1);
        check("glitch_no_frame_err", fe_cnt, 32'd0);

        // Bad stop bit
        base = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("stop0_frame_err_once", fe_cnt - base, 32'd1);
        check("stop0_empty", {31'd0, empty}, 32'd1);
        check("stop0_idle", {31'd0, busy}, 32'd0);

        // Fill the FIFO, then overflow
        auto_read = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 1'b0);
        end
        check("fill_full", {31'd0, full}, 32'd1);
        base = ov_cnt;
        send_frame(8'h05, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("fill_overflow_once", ov_cnt - base, 32'd1);
        check("fill_still_full", {31'd0, full}, 32'd1);
        check("fill_head", {24'd0, data_out}, 32'h01);
        auto_read = 1'b1;
        repeat (10) @(negedge clk);
        check("fill_drained_empty", {31'd0, empty}, 32'd1);
        check("fill_drained_queue", exp_q.size(), 32'd0);

        // Reset in the middle of 0xFF's data bits, then a clean 0x5A
        base = fe_cnt;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_nothing_pushed", {31'd0, empty}, 32'd1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("midrst_5a_read", exp_q.size(), 32'd0);
        check("midrst_no_frame_err", fe_cnt - base, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Bad parity: pulse, no push
        base = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("parity_err_once", pe_cnt - base, 32'd1);
        check("parity_no_push", {31'd0, empty}, 32'd1);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart to uart_tx in the UART block.
- Oversamples the serial line at SAMPLING_TICKS per bit and deserialises 8N1 frames, LSB first.
- Pushes each good byte into a small internal FIFO; the host drains it with rd_en.
- Reports framing errors and overflow as single-cycle pulses.

Parameters:
- WIDTH, 8, data bits per frame.
- SAMPLING_TICKS, 16, oversampling ticks per bit; must be even and ≥4.
- TICK_DIV, 1, clk cycles per sampling tick; bit period = TICK_DIV*SAMPLING_TICKS clks.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rd_en  input  1  pop FIFO head this cycle.
- data_out  output  WIDTH  FIFO head (show-ahead); valid when empty=0.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- busy  output  1  frame in progress (state != IDLE).
- frame_err  output  1  1-cycle pulse: stop bit sampled low.
- overflow  output  1  1-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset: synchroniser flops = 1, state = IDLE, all counters = 0, FIFO cleared.
  - Output reset values: empty=1, full=0, busy=0, frame_err=0, overflow=0, data_out=0.
  - Reset mid-frame abandons the frame and clears FIFO contents.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick generator: free-running counter asserts tick for 1 clk every TICK_DIV clks. TICK_DIV=1 means tick every clk.
- FSM advances only on tick cycles, using s_cnt (sample counter) and n (bit counter):
  - IDLE: rxs=0 → START, s_cnt=0.
  - START: s_cnt increments each tick. At s_cnt==SAMPLING_TICKS/2-1 (mid start bit):
    - rxs=0 → DATA, s_cnt=0, n=0.
    - rxs=1 → IDLE (glitch rejected, nothing reported).
  - DATA: at s_cnt==SAMPLING_TICKS-1, shift rxs into MSB of shift reg (LSB-first reception) and set s_cnt=0. After WIDTH bits → STOP (or PARITY when enabled).
  - STOP: at s_cnt==SAMPLING_TICKS-1 → IDLE, with one of:
    - rxs=1 and FIFO not full → push byte.
    - rxs=1 and FIFO full → drop byte, pulse overflow.
    - rxs=0 → discard byte, pulse frame_err.
- A line held low after a frame error retriggers START. A continuous break therefore yields repeated frame_err, one per frame time.
- Latency: empty deasserts and data_out is valid the clk after the stop-bit sample.
- FIFO behaviour:
  - rd_en while empty: ignored.
  - Push and rd_en in the same cycle while full: both succeed, no overflow.
  - Push and rd_en in the same cycle while empty: push lands, empty stays 1 for that cycle only.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, so full/empty are distinguished by the wrap bit.
- busy=1 from the IDLE→START transition until the return to IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP.
  - Samples one even-parity bit and adds output parity_err, a 1-cycle pulse at stop-sample time when parity mismatches.
  - A byte with bad parity is discarded and not pushed. frame_err still takes priority if the stop bit is also bad.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4;
  - default WIDTH / SAMPLING_TICKS constants, shared with uart_tx.
- One sub-module: uart_rx_fifo.
  - Parameters WIDTH and FIFO_DEPTH; push/pop/data/empty/full.
  - Same structure as the uart_tx FIFO.

Test Plan:
- Send 0xA5 as 8N1 at 16 clk/bit, no rd_en → empty falls ~160 clks after start edge; data_out=0xA5; busy=0 afterwards; frame_err=0.
- Loopback from uart_tx with bytes 0xA5, 0x3C, 0xFF, 0x00, read one per frame → read back in order; no error pulses.
- Drive rx low for 4 clks then high → FSM returns to IDLE; empty stays 1; no frame_err.
- Send 0x3C with stop bit =0 → frame_err pulses exactly 1 clk; empty stays 1.
- Send five bytes 0x01..0x05 with no reads (FIFO_DEPTH=4) → full=1 after the 4th; overflow pulse on the 5th; reads return 0x01..0x04, then empty=1.
- Assert rst mid-DATA of 0xFF, release, then send 0x5A → only 0x5A is received. Additionally, with UART_RX_PARITY_EN, sending 0x07 with parity bit 0 → parity_err pulse and no push.
